// File: rtl/pulse_gen_cascade.sv
// pulse_gen_cascade: multi-rate pulse generator for the stopwatch timebase.
//
// A prescaler divides clk5 by DIV to form the base tick. STAGES-1 cascaded
// modulo-STAGE_DIV counters then derive successively slower ticks. Each tick
// is registered into a one-cycle pulse. Each cascaded counter value is also
// exported for display logic.
//
// Ports:
//   clk5    in   system clock, rising edge
//   reset   in   synchronous active-low reset
//   en      in   run (1) / pause (0)
//   clr     in   synchronous clear of counters and outputs
//   pulse   out  [STAGES-1:0] one-cycle ticks, pulse[0] fastest
//   digits  out  [(STAGES-1)*STAGE_W-1:0] stage k counter at (k-1)*STAGE_W
//   sq      out  [STAGES-1:0] square waves toggling on each tick
//                (present only when PULSE_GEN_SQUARE_EN is defined)
//
// Optional feature macro: PULSE_GEN_SQUARE_EN

module pulse_gen_cascade #(
    parameter int unsigned DIV       = 500000,
    parameter int unsigned CNT_W     = 19,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned STAGE_DIV = 10,
    parameter int unsigned STAGE_W   = 4
) (
    input  logic                          clk5,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clr,
    output logic [STAGES-1:0]             pulse,
    output logic [(STAGES-1)*STAGE_W-1:0] digits
`ifdef PULSE_GEN_SQUARE_EN
    ,
    output logic [STAGES-1:0]             sq
`endif
);

    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    // Entry i holds the counter of cascaded stage i+1.
    logic [STAGES-2:0][STAGE_W-1:0]     stg_q, stg_d;
    logic [STAGES-1:0]                  tick;
    logic [STAGES-1:0]                  pulse_q;

    // Terminal-count chain: all ticks of one edge settle in the same cycle.
    // As a result, coincident wraps give coincident pulses.
    always_comb begin
        tick  = '0;
        cnt_d = cnt_q;
        stg_d = stg_q;
        if (en) begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
                cnt_d   = '0;
                tick[0] = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            for (int i = 0; i < int'(STAGES) - 1; i++) begin
                if (tick[i]) begin
                    if (stg_q[i] == STAGE_W'(STAGE_DIV - 1)) begin
                        stg_d[i]  = '0;
                        tick[i+1] = 1'b1;
                    end else begin
                        stg_d[i] = stg_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // tick is all-zero while paused, so pulse drops the edge after en falls.
    always_ff @(posedge clk5) begin
        if (!reset || clr) begin
            cnt_q   <= '0;
            stg_q   <= '0;
            pulse_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            pulse_q <= tick;
        end
    end

    assign pulse  = pulse_q;
    assign digits = stg_q;

`ifdef PULSE_GEN_SQUARE_EN
    logic [STAGES-1:0] sq_q;

    always_ff @(posedge clk5) begin
        if (!reset || clr) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_q ^ tick;
        end
    end

    assign sq = sq_q;
`endif

endmodule

// File: tb/tb_pulse_gen_cascade.sv
// Self-checking bench for pulse_gen_cascade. It uses a DIV=5 instance and a
// DIV=1 instance, and both share the same stimulus. Expected outputs come from
// a closed-form model of n, the number of counted (enabled) edges since the
// last clear. They are queued when an edge is driven and compared after that
// edge.

module tb_pulse_gen_cascade;

    logic       clk5;
    logic       reset;
    logic       en;
    logic       clr;
    logic [2:0] pulse, pulse1;
    logic [7:0] digits, digits1;
`ifdef PULSE_GEN_SQUARE_EN
    logic [2:0] sq, sq1;
`endif

    pulse_gen_cascade #(
        .DIV(5), .CNT_W(3), .STAGES(3), .STAGE_DIV(10), .STAGE_W(4)
    ) dut (
        .clk5   (clk5),
        .reset  (reset),
        .en     (en),
        .clr    (clr),
        .pulse  (pulse),
        .digits (digits)
`ifdef PULSE_GEN_SQUARE_EN
        ,
        .sq     (sq)
`endif
    );

    pulse_gen_cascade #(
        .DIV(1), .CNT_W(1), .STAGES(3), .STAGE_DIV(10), .STAGE_W(4)
    ) dut1 (
        .clk5   (clk5),
        .reset  (reset),
        .en     (en),
        .clr    (clr),
        .pulse  (pulse1),
        .digits (digits1)
`ifdef PULSE_GEN_SQUARE_EN
        ,
        .sq     (sq1)
`endif
    );

    typedef struct packed {
        logic [2:0] p;
        logic [7:0] d;
        logic [2:0] s;
        logic [2:0] p1;
        logic [7:0] d1;
        logic [2:0] s1;
    } obs_t;

    obs_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cnt   = 0;
    int   cyc     = 0;

    initial clk5 = 1'b0;
    always #5 clk5 = ~clk5;

    // Rate k fires every div*10^k counted edges. Stage k+1 digit = (n/(div*10^k)) % 10.
    function automatic void inst_exp(input int n, input bit counted, input int div,
                                     output logic [2:0] p, output logic [7:0] d,
                                     output logic [2:0] s);
        int r;
        r = div;
        p = '0;
        d = '0;
        s = '0;
        for (int k = 0; k < 3; k++) begin
            p[k] = counted && (n % r == 0);
`ifdef PULSE_GEN_SQUARE_EN
            s[k] = ((n / r) % 2) == 1;
`endif
            if (k < 2) d[k*4 +: 4] = 4'((n / r) % 10);
            r = r * 10;
        end
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o    = '0;
        o.p  = pulse;
        o.d  = digits;
        o.p1 = pulse1;
        o.d1 = digits1;
`ifdef PULSE_GEN_SQUARE_EN
        o.s  = sq;
        o.s1 = sq1;
`endif
        return o;
    endfunction

    // Drive one edge's inputs, queue the expected outputs, and advance past the edge.
    task automatic step(input bit rst_v, input bit clr_v, input bit en_v);
        obs_t e;
        bit   counted;
        reset = rst_v;
        clr   = clr_v;
        en    = en_v;
        counted = 1'b0;
        if (!rst_v || clr_v) begin
            n_cnt = 0;
        end else if (en_v) begin
            n_cnt++;
            counted = 1'b1;
        end
        inst_exp(n_cnt, counted, 5, e.p, e.d, e.s);
        inst_exp(n_cnt, counted, 1, e.p1, e.d1, e.s1);
        sb.push_back(e);
        @(posedge clk5);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            o = observed();
            n_tests++;
            if (o !== e || o !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want %h", cyc, o, e);
            end
        end
    endtask

    task automatic test_basic();
        obs_t e, o;
        step(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 510; i++) begin
            step(1'b1, 1'b0, 1'b1);
            e = sb.pop_front();
            o = observed();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic edge%0d: got %h want %h", i, o, e);
            end
            if (i == 5 || i == 50 || i == 500) begin
                n_tests++;
                if ((i == 5 && (digits[3:0] !== 4'd1 || pulse !== 3'b001)) ||
                    (i == 50 && (digits !== 8'h10 || pulse !== 3'b011)) ||
                    (i == 500 && (digits !== 8'h00 || pulse !== 3'b111))) begin
                    n_fail++;
                    $display("FAIL basic_mark edge%0d: pulse %b digits %h", i, pulse, digits);
                end
            end
        end
    endtask

    task automatic test_pause();
        obs_t e, o;
        step(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, !(i >= 22 && i <= 31));
            e = sb.pop_front();
            o = observed();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pause edge%0d: got %h want %h", i, o, e);
            end
            if ((i >= 22 && i <= 31) || i == 35) begin
                n_tests++;
                if ((i == 35 && pulse[0] !== 1'b1) ||
                    (i != 35 && (pulse !== 3'b000 || digits[3:0] !== 4'd4))) begin
                    n_fail++;
                    $display("FAIL pause_mark edge%0d: pulse %b digits %h", i, pulse, digits);
                end
            end
        end
    endtask

    task automatic test_clear(input bit en_at_clr);
        obs_t e, o;
        step(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, i == 23, (i == 23) ? en_at_clr : 1'b1);
            e = sb.pop_front();
            o = observed();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL clear(en=%0b) edge%0d: got %h want %h", en_at_clr, i, o, e);
            end
            if (i == 23 || i == 28) begin
                n_tests++;
                if ((i == 23 && (pulse !== 3'b000 || digits !== 8'h00)) ||
                    (i == 28 && pulse[0] !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL clear_mark edge%0d: pulse %b digits %h", i, pulse, digits);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        step(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 252; i++) begin
            step(i != 247, 1'b0, 1'b1);
            e = sb.pop_front();
            o = observed();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid edge%0d: got %h want %h", i, o, e);
            end
            if (i == 247 || i == 252) begin
                n_tests++;
                if ((i == 247 && (pulse !== 3'b000 || digits !== 8'h00)) ||
                    (i == 252 && pulse[0] !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL reset_mid_mark edge%0d: pulse %b digits %h", i, pulse, digits);
                end
            end
        end
    endtask

    task automatic test_div1();
        obs_t e, o;
        step(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b0, 1'b1);
            e = sb.pop_front();
            o = observed();
            n_tests++;
            if (o !== e || pulse1[0] !== 1'b1 || digits1[3:0] !== 4'(i % 10)
                || pulse1[1] !== (i % 10 == 0)) begin
                n_fail++;
                $display("FAIL div1 edge%0d: got %h want %h", i, o, e);
            end
        end
    endtask

`ifdef PULSE_GEN_SQUARE_EN
    task automatic test_square();
        obs_t e, o;
        step(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 110; i++) begin
            step(1'b1, 1'b0, 1'b1);
            e = sb.pop_front();
            o = observed();
            n_tests++;
            if (o !== e || sq[0] !== (((i / 5) % 2) == 1) || sq[1] !== (((i / 50) % 2) == 1)) begin
                n_fail++;
                $display("FAIL square edge%0d: got %h want %h", i, o, e);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        clr   = 1'b0;
        en    = 1'b0;
        test_reset();
        test_basic();
        test_pause();
        test_clear(1'b1);
        test_clear(1'b0);
        test_reset_mid();
        test_div1();
`ifdef PULSE_GEN_SQUARE_EN
        test_square();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
